fetch_unit_8085: RTL and testbench
==================================

Name: fetch_unit_8085

Overview:
- Instruction fetch stage directly upstream of processor_8085_single.
- Reads opcode and operand bytes from byte-wide synchronous program memory and determines instruction length (1/2/3 bytes) from the opcode.
- Presents one complete instruction per valid/ready handshake to the execute core.
- Owns the program counter; accepts redirects (JMP/CALL/RET/taken Jcc) from the core.

Parameters:
- ADDR_W, 16, program-memory address width; PC width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_addr  output  ADDR_W  program-memory byte address.
- mem_rd  output  1  read strobe; memory returns mem_rdata on the following cycle.
- mem_rdata  input  8  read data, valid the cycle after mem_rd.
- instr_valid  output  1  instruction bundle valid.
- instr_ready  input  1  core accepts the bundle.
- instr_op  output  8  opcode byte.
- instr_b2  output  8  second byte; 0 if len<2.
- instr_b3  output  8  third byte; 0 if len<3.
- instr_len  output  2  1, 2 or 3.
- instr_pc  output  ADDR_W  address of the opcode byte.
- redirect_en  input  1  load new PC; abort current fetch.
- redirect_addr  input  ADDR_W  redirect target.
- halted  output  1  fetch stopped on HLT. Constant 0 unless HLT_DETECT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=OP_A.
  - instr_valid=0; instr_op/b2/b3=0; instr_len=0; instr_pc=0; halted=0; mem_rd=0.
- mem_addr = pc combinationally at all times.
- States: OP_A, OP_D, B2_A, B2_D, B3_A, B3_D, VALID, HALT.
- Byte fetch takes 2 cycles:
  - *_A state: mem_rd=1 (address phase).
  - *_D state: mem_rd=0; capture mem_rdata; pc<=pc+1.
- OP_D:
  - Capture opcode; instr_pc<=pc.
  - len = fetch_len_8085(opcode).
  - len==1 -> VALID, else -> B2_A.
- B2_D: capture b2; len==2 -> VALID, else -> B3_A.
- B3_D: capture b3 -> VALID.
- Latency from entering OP_A to instr_valid=1: 2/4/6 cycles for 1/2/3-byte instructions.
- VALID:
  - instr_valid=1; all instr_* held stable until instr_valid&&instr_ready.
  - On accept -> OP_A next cycle; instr_valid drops to 0.
  - instr_ready while not valid is ignored.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000. An instruction may straddle the wrap.
- redirect_en has highest priority in every state:
  - pc<=redirect_addr; state<=OP_A; instr_valid<=0; in-flight bytes discarded.
  - Memory data returning in the following cycle is ignored.
- redirect_en in the same cycle as a VALID accept: the handshake completes (instruction consumed) and the redirect is applied. There is no double-count.
- Back-to-back redirects: the last one wins.
- Reset asserted mid-fetch: immediate return to reset state; no partial instruction is ever presented.
- Undefined 8085 opcodes are treated as length 1.

Optional Feature:
- Macro HLT_DETECT_EN.
- Defined:
  - When a bundle with instr_op==8'h76 is accepted, next state is HALT.
  - HALT: mem_rd=0, halted=1, pc frozen, instr_valid=0.
  - HALT is left only by redirect_en (-> OP_A, halted=0) or reset.
- Undefined:
  - 8'h76 is an ordinary 1-byte instruction; fetch continues at pc.
  - No HALT state; halted tied 0.

Decomposition:
- Package fetch_pkg_8085 holds:
  - state enum/localparams;
  - HLT opcode constant 8'h76;
  - function fetch_len_8085(op) returning 2'd1/2/3.
- Length rules:
  - 2-byte: 00rrr110 (MVI), 11xxx110 (immediate ALU), D3, DB.
  - 3-byte: 00rr0001 (LXI), 22, 2A, 32, 3A, C3, CD, 11ccc010 (Jcc), 11ccc100 (Ccc).
  - All others: 1.
- No sub-module: FSM plus capture registers in one module.

Test Plan:
- Mem[0..1]=3E,05; instr_ready=1 -> instr_valid 4 cycles after reset release with op=3E, b2=05, b3=00, len=2, instr_pc=0000.
- Mem[2..4]=C3,34,12; hold instr_ready=0 for 5 cycles -> bundle C3/34/12, len=3, instr_pc=0002 stays stable; accepted on ready; next fetch at pc=0005.
- Single byte 80 (ADD B) at 0005 -> instr_valid 2 cycles after OP_A, len=1, b2=b3=00.
- redirect_en with addr=1234 during B2_D of a 3-byte fetch -> no bundle presented; next mem_addr=1234 with mem_rd=1.
- pc=FFFF, mem[FFFF]=06, mem[0000]=AA -> bundle op=06, b2=AA, instr_pc=FFFF; pc=0001 afterwards.
- HLT_DETECT_EN: 76 accepted -> halted=1, mem_rd=0 for 20 cycles; redirect to 0010 -> halted=0, fetch at 0010. Without the macro: fetch continues at next address.

Source files
------------

// File: rtl/fetch_pkg_8085.sv
// Shared types for the 8085 fetch stage: FSM states, the HLT opcode and the
// opcode-to-length decoder used to decide how many operand bytes follow.
package fetch_pkg_8085;

  typedef enum logic [2:0] {
    OP_A,
    OP_D,
    B2_A,
    B2_D,
    B3_A,
    B3_D,
    VALID,
    HALT
  } state_t;

  localparam logic [7:0] HLT_OP = 8'h76;

  // Undefined opcodes fall through to length 1.
  function automatic logic [1:0] fetch_len_8085(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if ((op[7:6] == 2'b00 && op[3:0] == 4'b0001) ||
        op == 8'h22 || op == 8'h2A || op == 8'h32 || op == 8'h3A ||
        op == 8'hC3 || op == 8'hCD ||
        (op[7:6] == 2'b11 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)))
      len = 2'd3;
    else if ((op[2:0] == 3'b110 && (op[7:6] == 2'b00 || op[7:6] == 2'b11)) ||
             op == 8'hD3 || op == 8'hDB)
      len = 2'd2;
    return len;
  endfunction

endpackage

// File: rtl/fetch_unit_8085.sv
// 8085 fetch: 2 cycles per byte, bundle valid 2/4/6 cycles after OP_A; bundle held until accepted.
// Redirect beats everything; HLT_DETECT_EN adds a HALT state left only by redirect or reset.
module fetch_unit_8085
  import fetch_pkg_8085::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_op,
  output logic [7:0]        instr_b2,
  output logic [7:0]        instr_b3,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;

  assign mem_addr = pc;
  // Read strobe is a pure decode of the address-phase states, forced low in reset.
  assign mem_rd   = rst_n && (state == OP_A || state == B2_A || state == B3_A);

`ifndef HLT_DETECT_EN
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OP_A;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_op    <= 8'h00;
      instr_b2    <= 8'h00;
      instr_b3    <= 8'h00;
      instr_len   <= 2'd0;
      instr_pc    <= '0;
`ifdef HLT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else if (redirect_en) begin
      // Any byte returning next cycle lands in OP_A, which never captures it.
      state       <= OP_A;
      pc          <= redirect_addr;
      instr_valid <= 1'b0;
`ifdef HLT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        OP_A: state <= OP_D;
        OP_D: begin
          instr_op  <= mem_rdata;
          instr_b2  <= 8'h00;
          instr_b3  <= 8'h00;
          instr_len <= fetch_len_8085(mem_rdata);
          instr_pc  <= pc;
          pc        <= pc + ADDR_W'(1);
          if (fetch_len_8085(mem_rdata) == 2'd1) begin
            state       <= VALID;
            instr_valid <= 1'b1;
          end else begin
            state <= B2_A;
          end
        end
        B2_A: state <= B2_D;
        B2_D: begin
          instr_b2 <= mem_rdata;
          pc       <= pc + ADDR_W'(1);
          if (instr_len == 2'd2) begin
            state       <= VALID;
            instr_valid <= 1'b1;
          end else begin
            state <= B3_A;
          end
        end
        B3_A: state <= B3_D;
        B3_D: begin
          instr_b3    <= mem_rdata;
          pc          <= pc + ADDR_W'(1);
          state       <= VALID;
          instr_valid <= 1'b1;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
`ifdef HLT_DETECT_EN
            if (instr_op == HLT_OP) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= OP_A;
            end
`else
            state <= OP_A;
`endif
          end
        end
        HALT: begin
`ifdef HLT_DETECT_EN
          state <= HALT;
`else
          state <= OP_A;
`endif
        end
        default: state <= OP_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit_8085.sv
// Bench for fetch_unit_8085: directed latency/redirect/wrap/reset cases, then
// random programs with random ready and redirects checked against an opcode-table model.
module tb_fetch_unit_8085;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic [7:0]  instr_b2;
  logic [7:0]  instr_b3;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect_en;
  logic [15:0] redirect_addr;
  logic        halted;

  logic [7:0]  mem [0:65535];
  int          n_tests;
  int          n_fail;

  fetch_unit_8085 #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_b2     (instr_b2),
    .instr_b3     (instr_b3),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data one cycle after the read strobe.
  initial mem_rdata = 8'h00;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Instruction lengths listed opcode by opcode from the 8085 instruction set.
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hD3, 8'hDB:
        return 2'd2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
      8'hC3, 8'hCD,
      8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2, 8'hFA,
      8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC:
        return 2'd3;
      default:
        return 2'd1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int exp_cycles);
    int c;
    c = 0;
    while (!instr_valid && c < 20) begin
      tick();
      c++;
    end
    check(tag, c, exp_cycles);
  endtask

  task automatic check_bundle(input string tag, input logic [7:0] op, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [1:0] len, input logic [15:0] pc);
    check({tag, "_bytes"}, {6'd0, instr_len, instr_op, instr_b2, instr_b3}, {6'd0, len, op, b2, b3});
    check({tag, "_pc"}, {16'd0, instr_pc}, {16'd0, pc});
  endtask

  logic [15:0] model_pc;
  logic [15:0] tgt;
  logic [7:0]  eop, eb2, eb3;
  logic [1:0]  elen;
  int          gap, max_gap, n_acc, bad;
  bit          r, rd;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_addr = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h3E; mem[16'h0001] = 8'h05;
    mem[16'h0002] = 8'hC3; mem[16'h0003] = 8'h34; mem[16'h0004] = 8'h12;
    mem[16'h0005] = 8'h80;
    mem[16'h0006] = 8'h21; mem[16'h0007] = 8'h99; mem[16'h0008] = 8'h88;
    mem[16'hFFFF] = 8'h06;
    mem[16'h0100] = 8'h76;
    mem[16'h0200] = 8'hCD; mem[16'h0201] = 8'h11; mem[16'h0202] = 8'h22;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
    check_bundle("rst", 8'h00, 8'h00, 8'h00, 2'd0, 16'h0000);

    // MVI A,05 straight out of reset
    instr_ready = 1'b1;
    rst_n = 1'b1;
    wait_valid("lat_mvi", 4);
    check_bundle("mvi", 8'h3E, 8'h05, 8'h00, 2'd2, 16'h0000);
    tick();
    instr_ready = 1'b0;

    // JMP 1234 held under backpressure
    wait_valid("lat_jmp", 6);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!instr_valid || instr_op != 8'hC3 || instr_b2 != 8'h34 || instr_b3 != 8'h12 ||
          instr_len != 2'd3 || instr_pc != 16'h0002) bad++;
      tick();
    end
    check("jmp_hold_stable", bad, 0);
    check_bundle("jmp", 8'hC3, 8'h34, 8'h12, 2'd3, 16'h0002);
    instr_ready = 1'b1;
    tick();
    check("jmp_accept_valid", {31'd0, instr_valid}, 32'd0);
    check("jmp_next_addr", {16'd0, mem_addr}, 32'h0005);
    check("jmp_next_rd", {31'd0, mem_rd}, 32'd1);

    // ADD B
    wait_valid("lat_add", 2);
    check_bundle("add", 8'h80, 8'h00, 8'h00, 2'd1, 16'h0005);
    tick();

    // Redirect during B2_D of LXI at 0006
    repeat (3) tick();
    redirect_en = 1'b1;
    redirect_addr = 16'h1234;
    tick();
    redirect_en = 1'b0;
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", {16'd0, mem_addr}, 32'h1234);
    check("redir_rd", {31'd0, mem_rd}, 32'd1);
    wait_valid("lat_redir", 2);
    check_bundle("redir", 8'h00, 8'h00, 8'h00, 2'd1, 16'h1234);

    // Accept and redirect in the same cycle, into an instruction straddling the wrap
    mem[16'h0000] = 8'hAA;
    redirect_en = 1'b1;
    redirect_addr = 16'hFFFF;
    tick();
    redirect_en = 1'b0;
    check("wrap_valid_drop", {31'd0, instr_valid}, 32'd0);
    wait_valid("lat_wrap", 4);
    check_bundle("wrap", 8'h06, 8'hAA, 8'h00, 2'd2, 16'hFFFF);
    check("wrap_pc_after", {16'd0, mem_addr}, 32'h0001);

    // HLT
    redirect_en = 1'b1;
    redirect_addr = 16'h0100;
    tick();
    redirect_en = 1'b0;
    wait_valid("lat_hlt", 2);
    check_bundle("hlt", 8'h76, 8'h00, 8'h00, 2'd1, 16'h0100);
    tick();
`ifdef HLT_DETECT_EN
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!halted || mem_rd || instr_valid || mem_addr != 16'h0101) bad++;
      tick();
    end
    check("halt_hold", bad, 0);
    redirect_en = 1'b1;
    redirect_addr = 16'h0010;
    tick();
    redirect_en = 1'b0;
    check("halt_exit", {31'd0, halted}, 32'd0);
    check("halt_exit_addr", {16'd0, mem_addr}, 32'h0010);
    check("halt_exit_rd", {31'd0, mem_rd}, 32'd1);
    wait_valid("lat_after_halt", 2);
    check_bundle("after_halt", 8'h00, 8'h00, 8'h00, 2'd1, 16'h0010);
`else
    check("no_halt", {31'd0, halted}, 32'd0);
    wait_valid("lat_after_hlt", 2);
    check_bundle("after_hlt", 8'h00, 8'h00, 8'h00, 2'd1, 16'h0101);
`endif

    // Reset in the middle of a CALL fetch
    mem[16'h0000] = 8'h06;
    redirect_en = 1'b1;
    redirect_addr = 16'h0200;
    tick();
    redirect_en = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_rd", {31'd0, mem_rd}, 32'd0);
    check("midrst_addr", {16'd0, mem_addr}, 32'h0000);
    check_bundle("midrst", 8'h00, 8'h00, 8'h00, 2'd0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_valid("lat_postrst", 4);
    check_bundle("postrst", 8'h06, 8'h05, 8'h00, 2'd2, 16'h0000);

    // Random programs, random backpressure and redirects
    for (int i = 0; i < 260; i++) begin
      eop = 8'($urandom_range(0, 255));
      if (eop == 8'h76) eop = 8'h00;
      mem[16'h4000 + 16'(i)] = eop;
    end
    instr_ready = 1'b0;
    redirect_en = 1'b1;
    redirect_addr = 16'h4000;
    model_pc = 16'h4000;
    tick();
    redirect_en = 1'b0;
    gap = 0;
    max_gap = 0;
    n_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (instr_valid) gap = 0;
      else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      r   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      tgt = 16'h4000 + 16'($urandom_range(0, 255));
      instr_ready   = r;
      redirect_en   = rd;
      redirect_addr = tgt;
      if (instr_valid && r) begin
        eop  = mem[model_pc];
        elen = ref_len(eop);
        eb2  = (elen >= 2'd2) ? mem[model_pc + 16'd1] : 8'h00;
        eb3  = (elen == 2'd3) ? mem[model_pc + 16'd2] : 8'h00;
        check_bundle("rand", eop, eb2, eb3, elen, model_pc);
        model_pc = model_pc + {14'd0, elen};
        n_acc++;
      end
      if (rd) begin
        model_pc = tgt;
        gap = 0;
      end
      tick();
    end
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    check("rand_progress", {31'd0, (n_acc > 100)}, 32'd1);
    check("rand_max_gap", {31'd0, (max_gap <= 6)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
